// File: rtl/uart_pkg.sv
// Shared UART types and oversampling constants for the RX (and future TX) paths.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_PT  = 7;
    localparam int unsigned OS_W       = $clog2(OVERSAMPLE);

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; pop_data always shows the head entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;
    logic             do_push;

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= push_data;
                wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign pop_data = mem[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receiver: input synchroniser, 16x oversampling FSM, RX FIFO and sticky error flags.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_uart_rx,
    input  logic [DIV_W-1:0]              i_baud_div,
    output logic [7:0]                    o_rx_data,
    output logic                          o_rx_valid,
    input  logic                          i_rx_ready,
    output logic                          o_frame_err,
    output logic                          o_overrun,
    input  logic                          i_err_clr,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev_q;
    logic                   fall_c;
    logic [DIV_W-1:0]       div_eff;
    logic [DIV_W-1:0]       baud_cnt_q;
    logic                   tick_c;
    logic [OS_W-1:0]        os_cnt_q;
    logic                   sample_c;
    logic                   boundary_c;
    rx_state_e              state_q;
    rx_state_e              state_d;
    logic [3:0]             bit_cnt_q;
    logic [3:0]             bit_cnt_d;
    logic [7:0]             shreg_q;
    logic                   shift_c;
    logic                   push_c;
    logic                   frame_set_c;
    logic                   overrun_set_c;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   frame_err_q;
    logic                   overrun_q;

    // Metastability synchroniser plus one more flop for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_uart_rx};
            rx_prev_q <= rx_s;
        end
    end

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign fall_c = rx_prev_q && !rx_s;

    // Comparing with >= lets a divisor change land cleanly at the next wrap.
    assign div_eff    = (i_baud_div == '0) ? DIV_W'(1) : i_baud_div;
    assign tick_c     = (state_q != IDLE) && (baud_cnt_q >= div_eff - DIV_W'(1));
    assign sample_c   = tick_c && (os_cnt_q == OS_W'(SAMPLE_PT));
    assign boundary_c = tick_c && (os_cnt_q == OS_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt_q <= '0;
            os_cnt_q   <= '0;
        end else if (state_q == IDLE) begin
            baud_cnt_q <= '0;
            os_cnt_q   <= '0;
        end else if (tick_c) begin
            baud_cnt_q <= '0;
            os_cnt_q   <= os_cnt_q + OS_W'(1);
        end else begin
            baud_cnt_q <= baud_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            if (shift_c) begin
                shreg_q <= {rx_s, shreg_q[7:1]};
            end
        end
    end

    // bit_cnt counts sampled data bits, so the start bit's own boundary inside DATA is ignored.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_c     = 1'b0;
        push_c      = 1'b0;
        frame_set_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall_c) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample_c) begin
                    state_d   = rx_s ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (sample_c) begin
                    shift_c   = 1'b1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (boundary_c && (bit_cnt_q == 4'd8)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample_c) begin
                    state_d     = IDLE;
                    push_c      = rx_s;
                    frame_set_c = !rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign overrun_set_c = push_c && fifo_full && !(i_rx_ready && !fifo_empty);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_c),
        .push_data (shreg_q),
        .pop       (i_rx_ready),
        .pop_data  (o_rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_set_c   || (frame_err_q && !i_err_clr);
            overrun_q   <= overrun_set_c || (overrun_q   && !i_err_clr);
        end
    end

    assign o_rx_valid   = !fifo_empty;
    assign o_fifo_count = fifo_count;
    assign o_frame_err  = frame_err_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = (state_q != IDLE);

endmodule
